// File: rtl/mem_read_arbiter.sv
// Two-requester read arbiter sharing a single DDR3 read port, one read outstanding at a time.
// Winner is picked in IDLE by round-robin or fixed r0 priority; read data is passed through to both.
module mem_read_arbiter #(
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_l,
  input  logic              prio_mode,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_read_en,
  output logic              r0_wait,
  output logic [DATA_W-1:0] r0_data,
  output logic              r0_ack,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_read_en,
  output logic              r1_wait,
  output logic [DATA_W-1:0] r1_data,
  output logic              r1_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  input  logic              mem_wait,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic              r_owner, w_owner_next;
  logic              r_last_grant, w_last_grant_next;
  logic              w_winner;
  logic              w_accept;

  // On a tie in round-robin mode the requester not granted last time wins.
  always_comb begin
    w_winner = 1'b0;
    if (r0_read_en && r1_read_en) begin
      w_winner = prio_mode ? 1'b0 : ~r_last_grant;
    end else if (r1_read_en) begin
      w_winner = 1'b1;
    end
  end

  assign w_accept = (r_state == StIdle) && (r0_read_en || r1_read_en);

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_owner_next      = r_owner;
    w_last_grant_next = r_last_grant;
    mem_read_en       = 1'b0;
    r0_ack            = 1'b0;
    r1_ack            = 1'b0;
    r0_wait           = ~(w_accept && !w_winner);
    r1_wait           = ~(w_accept && w_winner);
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_addr_next       = w_winner ? r1_addr : r0_addr;
          w_owner_next      = w_winner;
          w_last_grant_next = w_winner;
          w_state_next      = StIssue;
        end
      end
      StIssue: begin
        mem_read_en = 1'b1;
        if (!mem_wait) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (mem_ack) begin
          r0_ack       = ~r_owner;
          r1_ack       = r_owner;
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_owner      <= w_owner_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  assign mem_addr = r_addr;
  assign r0_data  = mem_data;
  assign r1_data  = mem_data;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a cycle-by-cycle vector table plus hand-written
// contention and reset-in-RESP sequences.
module tb_mem_read_arbiter;

  localparam int unsigned ADDR_W = 29;
  localparam int unsigned DATA_W = 64;

  logic              clock;
  logic              reset_l;
  logic              prio_mode;
  logic [ADDR_W-1:0] r0_addr, r1_addr, mem_addr;
  logic              r0_read_en, r1_read_en;
  logic              r0_wait, r1_wait, r0_ack, r1_ack;
  logic [DATA_W-1:0] r0_data, r1_data, mem_data;
  logic              mem_read_en, mem_wait, mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  mem_read_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock      (clock),
    .reset_l    (reset_l),
    .prio_mode  (prio_mode),
    .r0_addr    (r0_addr),
    .r0_read_en (r0_read_en),
    .r0_wait    (r0_wait),
    .r0_data    (r0_data),
    .r0_ack     (r0_ack),
    .r1_addr    (r1_addr),
    .r1_read_en (r1_read_en),
    .r1_wait    (r1_wait),
    .r1_data    (r1_data),
    .r1_ack     (r1_ack),
    .mem_addr   (mem_addr),
    .mem_read_en(mem_read_en),
    .mem_wait   (mem_wait),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic              prio;
    logic              r0_en;
    logic              r1_en;
    logic [ADDR_W-1:0] r0_a;
    logic [ADDR_W-1:0] r1_a;
    logic              mw;
    logic              ma;
    logic [DATA_W-1:0] md;
    logic              e_w0;
    logic              e_w1;
    logic              e_a0;
    logic              e_a1;
    logic              e_rd;
    logic [ADDR_W-1:0] e_maddr;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic p, input logic e0, input logic e1,
                              input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                              input logic mw, input logic ma, input logic [DATA_W-1:0] md,
                              input logic w0, input logic w1, input logic k0, input logic k1,
                              input logic rd, input logic [ADDR_W-1:0] maddr);
    vec_t v;
    v.prio = p; v.r0_en = e0; v.r1_en = e1; v.r0_a = a0; v.r1_a = a1;
    v.mw = mw; v.ma = ma; v.md = md;
    v.e_w0 = w0; v.e_w1 = w1; v.e_a0 = k0; v.e_a1 = k1; v.e_rd = rd; v.e_maddr = maddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    prio_mode = 1'b0; r0_read_en = 1'b0; r1_read_en = 1'b0;
    r0_addr = '0; r1_addr = '0; mem_wait = 1'b0; mem_ack = 1'b0; mem_data = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".mem_read_en"}, 64'(mem_read_en), 64'd0);
    check({tag, ".r0_wait"}, 64'(r0_wait), 64'd1);
    check({tag, ".r1_wait"}, 64'(r1_wait), 64'd1);
    check({tag, ".r0_ack"}, 64'(r0_ack), 64'd0);
    check({tag, ".r1_ack"}, 64'(r1_ack), 64'd0);
  endtask

  // Six back-to-back reads with both requesters active; bit i of exp_win is the i-th winner id.
  task automatic run_grants(input logic prio, input logic [5:0] exp_win, input string tag);
    logic w;
    logic [ADDR_W-1:0] a0, a1;
    for (int i = 0; i < 6; i++) begin
      w  = exp_win[i];
      a0 = ADDR_W'(32'h10 + i);
      a1 = ADDR_W'(32'h20 + i);
      @(negedge clock);
      prio_mode = prio; r0_read_en = 1'b1; r1_read_en = 1'b1;
      r0_addr = a0; r1_addr = a1; mem_wait = 1'b0; mem_ack = 1'b0;
      #1;
      check($sformatf("%s.g%0d.r0_wait", tag, i), 64'(r0_wait), 64'(w));
      check($sformatf("%s.g%0d.r1_wait", tag, i), 64'(r1_wait), 64'(!w));
      @(negedge clock);
      prio_mode = ~prio;  // must not matter outside IDLE
      #1;
      check($sformatf("%s.g%0d.mem_read_en", tag, i), 64'(mem_read_en), 64'd1);
      check($sformatf("%s.g%0d.mem_addr", tag, i), 64'(mem_addr), 64'(w ? a1 : a0));
      check($sformatf("%s.g%0d.issue_r1_wait", tag, i), 64'(r1_wait), 64'd1);
      @(negedge clock);
      mem_ack = 1'b1; mem_data = 64'hA000 + 64'(i);
      #1;
      check($sformatf("%s.g%0d.r0_ack", tag, i), 64'(r0_ack), 64'(!w));
      check($sformatf("%s.g%0d.r1_ack", tag, i), 64'(r1_ack), 64'(w));
    end
    @(negedge clock);
    drive_idle();
  endtask

  localparam logic [DATA_W-1:0] D0 = 64'h0123456789ABCDEF;
  localparam logic [ADDR_W-1:0] AMAX = 29'h1FFFFFFF;

  initial begin
    vecs[0]  = mk(0, 1, 0, 29'h100, 0, 0, 0, 0,  0, 1, 0, 0, 0, 29'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 1, 0, 0, 1, 29'h100);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, D0,       1, 1, 1, 0, 0, 29'h100);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 1, 0, 0, 0, 29'h100);
    vecs[4]  = mk(0, 0, 1, 0, AMAX, 0, 0, 0,     1, 0, 0, 0, 0, 29'h100);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0,        1, 1, 0, 0, 1, AMAX);
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0,        1, 1, 0, 0, 1, AMAX);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0,        1, 1, 0, 0, 1, AMAX);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0,        1, 1, 0, 0, 1, AMAX);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 1, 0, 0, 1, AMAX);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 64'hCAFEF00DDEADBEEF, 1, 1, 0, 1, 0, AMAX);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 1, 0, 0, 0, AMAX);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 64'hDEAD, 1, 1, 0, 0, 0, AMAX);
    vecs[13] = mk(0, 1, 1, 29'h55, 29'h77, 0, 0, 0, 0, 1, 0, 0, 0, AMAX);
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 1, 64'h1,    1, 1, 0, 0, 1, 29'h55);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 64'h2,    1, 1, 0, 0, 1, 29'h55);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 64'h3,    1, 1, 1, 0, 0, 29'h55);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 1, 0, 0, 0, 29'h55);

    drive_idle();
    reset_l = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_quiet("reset");
    check("reset.mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clock);
    reset_l = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      prio_mode = vecs[i].prio; r0_read_en = vecs[i].r0_en; r1_read_en = vecs[i].r1_en;
      r0_addr = vecs[i].r0_a; r1_addr = vecs[i].r1_a;
      mem_wait = vecs[i].mw; mem_ack = vecs[i].ma; mem_data = vecs[i].md;
      #1;
      check($sformatf("v%0d.r0_wait", i), 64'(r0_wait), 64'(vecs[i].e_w0));
      check($sformatf("v%0d.r1_wait", i), 64'(r1_wait), 64'(vecs[i].e_w1));
      check($sformatf("v%0d.r0_ack", i), 64'(r0_ack), 64'(vecs[i].e_a0));
      check($sformatf("v%0d.r1_ack", i), 64'(r1_ack), 64'(vecs[i].e_a1));
      check($sformatf("v%0d.mem_read_en", i), 64'(mem_read_en), 64'(vecs[i].e_rd));
      check($sformatf("v%0d.mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_maddr));
      check($sformatf("v%0d.r0_data", i), r0_data, vecs[i].md);
      check($sformatf("v%0d.r1_data", i), r1_data, vecs[i].md);
    end

    // Reset so last_grant points at r1 and r0 wins the first tie.
    @(negedge clock);
    drive_idle();
    reset_l = 1'b0;
    @(negedge clock);
    reset_l = 1'b1;
    run_grants(1'b0, 6'b101010, "rr");
    run_grants(1'b1, 6'b000000, "fixed");

    // Reset while a read sits in RESP.
    @(negedge clock);
    r0_read_en = 1'b1; r0_addr = 29'h1234;
    #1;
    check("rst.accept_r0_wait", 64'(r0_wait), 64'd0);
    @(negedge clock);
    r0_read_en = 1'b0;
    #1;
    check("rst.issue_rd", 64'(mem_read_en), 64'd1);
    @(negedge clock);
    reset_l = 1'b0;
    mem_ack = 1'b1; mem_data = 64'h5555;
    #1;
    check_quiet("rst.in_resp");
    check("rst.in_resp.mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clock);
    reset_l = 1'b1;
    #1;
    check_quiet("rst.late_ack0");
    @(negedge clock);
    #1;
    check_quiet("rst.late_ack1");
    @(negedge clock);
    mem_ack = 1'b0;
    r0_read_en = 1'b1; r0_addr = 29'h0ABC;
    #1;
    check("rst.new_r0_wait", 64'(r0_wait), 64'd0);
    @(negedge clock);
    r0_read_en = 1'b0;
    #1;
    check("rst.new_rd", 64'(mem_read_en), 64'd1);
    check("rst.new_addr", 64'(mem_addr), 64'h0ABC);
    @(negedge clock);
    mem_ack = 1'b1; mem_data = 64'h7777;
    #1;
    check("rst.new_r0_ack", 64'(r0_ack), 64'd1);
    check("rst.new_r1_ack", 64'(r1_ack), 64'd0);
    check("rst.new_r0_data", r0_data, 64'h7777);
    @(negedge clock);
    drive_idle();
    #1;
    check_quiet("rst.done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 29, DDR3 word address width.
- DATA_W, 64, read data width.
REQ-002 Ports SHALL be (name direction width meaning):
- clock in 1: single clock for all logic.
- reset_l in 1: asynchronous, active-low reset.
- prio_mode in 1: 0 = round-robin, 1 = fixed priority to r0.
- r0_addr in ADDR_W: requester 0 read address (sample fetcher).
- r0_read_en in 1: requester 0 read request.
- r0_wait out 1: requester 0 stall.
- r0_data out DATA_W: requester 0 read data.
- r0_ack out 1: requester 0 read data valid.
- r1_addr in ADDR_W: requester 1 read address.
- r1_read_en in 1: requester 1 read request.
- r1_wait out 1: requester 1 stall.
- r1_data out DATA_W: requester 1 read data.
- r1_ack out 1: requester 1 read data valid.
- mem_addr out ADDR_W: shared DDR3 read address.
- mem_read_en out 1: shared DDR3 read request.
- mem_wait in 1: DDR3 command stall.
- mem_data in DATA_W: DDR3 read data.
- mem_ack in 1: DDR3 read data valid.

Function
REQ-003 Block SHALL share one DDR3 read port between r0 and r1, with at most one read outstanding.
REQ-004 FSM SHALL have states IDLE, ISSUE and RESP.
REQ-005 Requester handshake: a request is accepted at the edge where rX_read_en=1 and rX_wait=0. The requester holds rX_addr and rX_read_en stable while rX_wait=1.
REQ-006 rX_wait SHALL be 0 only in IDLE, only for the current cycle's winner, and only when that requester's read_en=1; otherwise rX_wait SHALL be 1.
REQ-007 Winner selection in IDLE:
- One requester active: that requester wins.
- Both active, prio_mode=1: r0 wins.
- Both active, prio_mode=0: the requester not recorded in last_grant wins.
REQ-008 On acceptance the block SHALL:
- latch rX_addr into addr_q;
- latch the winner id into owner_q;
- set last_grant to the winner id;
- go to ISSUE.
REQ-009 In ISSUE: mem_read_en=1 and mem_addr=addr_q.
- Edge with mem_wait=0: go to RESP.
- Edge with mem_wait=1: stay in ISSUE with addr_q unchanged.
REQ-010 In IDLE and RESP: mem_read_en=0 and mem_addr=addr_q.
REQ-011 In RESP, while mem_ack=1, the owner's rX_ack SHALL be 1 combinationally (zero-cycle pass-through); the FSM SHALL go to IDLE at that edge.
REQ-012 r0_data and r1_data SHALL both equal mem_data at all times; only rX_ack qualifies the data.
REQ-013 mem_ack in IDLE or ISSUE SHALL be ignored and SHALL produce no rX_ack.
REQ-014 The non-owner rX_ack SHALL never assert.
REQ-015 At most one rX_ack SHALL be high per cycle.
REQ-016 Minimum request-to-data latency, from requester accept edge, with mem_wait=0 and mem_ack one cycle after the command: ack asserts 2 cycles later.
REQ-017 Back-to-back: arbitration SHALL resume in the IDLE cycle immediately after RESP. Maximum rate is one read per 3 cycles.
REQ-018 A requester that deasserts read_en while waiting SHALL be dropped without side effects.
REQ-019 prio_mode is sampled only in IDLE; a change mid-transaction SHALL affect only the next arbitration.
REQ-020 With prio_mode=0 and both requesters continuously active, grants SHALL strictly alternate r0, r1, r0, ...

Reset
REQ-021 When reset_l=0, asynchronously:
- state=IDLE, addr_q=0, owner_q=0, last_grant=1 (r0 wins the first tie);
- mem_read_en=0, mem_addr=0, r0_ack=0, r1_ack=0;
- r0_wait=1, r1_wait=1.
REQ-022 Reset mid-transaction (ISSUE or RESP) SHALL abandon the outstanding read. A late mem_ack after reset release SHALL be ignored per REQ-013.

Verification
REQ-023 Single read, r0 only: r0_addr=0x0000100, mem_wait=0, mem_ack with mem_data=0x0123456789ABCDEF one cycle after the command.
- Expect mem_addr=0x0000100 with mem_read_en for exactly 1 cycle.
- Expect r0_ack for 1 cycle with r0_data=0x0123456789ABCDEF.
- Expect r1_ack=0 throughout.
REQ-024 Stall: r1 read at 0x1FFFFFFF, mem_wait=1 for 4 cycles.
- Expect mem_read_en=1 and mem_addr=0x1FFFFFFF held for 5 cycles.
- Expect one r1_ack afterward.
REQ-025 Contention: prio_mode=0, r0 and r1 both continuously requesting for 6 reads.
- Expect grant order r0,r1,r0,r1,r0,r1.
- Repeat with prio_mode=1: expect all six grants to r0 while r1_wait stays 1.
REQ-026 Spurious ack: mem_ack=1 in IDLE and in ISSUE -> r0_ack=0 and r1_ack=0, state unchanged.
REQ-027 Reset in RESP:
- Expect mem_read_en=0, both waits=1, both acks=0.
- After release, a mem_ack produces no ack.
- A new r0 request completes normally.
